// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the memory arbiter: the word type, the RAM handshake
// states and the arbiter FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DGNT = 2'd1,
    IGNT = 2'd2
  } arb_state_t;

  localparam int unsigned STARVE_W = 3;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the icache, dcache and RAM signals around the arbiter. The master
// modport is the arbiter; the slave modport is the caches plus the RAM.
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  logic      iREN;
  word_t     iaddr;
  word_t     iload;
  logic      iwait;

  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  word_t     dload;
  logic      dwait;

  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/mem_arbiter.sv
// Two-requester RAM arbiter: dcache has priority, but the icache is forced
// through after STARVE_MAX consecutive dcache completions while it waits.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          CLK,
  input  logic          RST,
  mem_arbiter_if.master bus
);

  localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_MAX[STARVE_W-1:0];

  arb_state_t          state;
  arb_state_t          next_state;
  logic [STARVE_W-1:0] starve_cnt;
  logic [STARVE_W-1:0] next_cnt;
  logic                dreq;
  logic                access;
  logic                starved;

  assign dreq    = bus.dREN | bus.dWEN;
  assign access  = (bus.ramstate == ACCESS);
  assign starved = bus.iREN && (starve_cnt == STARVE_LIMIT);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= next_state;
      starve_cnt <= next_cnt;
    end
  end

  // A grant ends on completion or when its requester withdraws; only a real
  // completion touches the starvation counter.
  always_comb begin
    next_state = state;
    next_cnt   = starve_cnt;
    unique case (state)
      IDLE: begin
        if (!bus.iREN) next_cnt = '0;
        if (dreq && !starved) next_state = DGNT;
        else if (bus.iREN)    next_state = IGNT;
        else                  next_state = IDLE;
      end
      DGNT: begin
        if (!dreq) begin
          next_state = IDLE;
        end else if (access) begin
          next_state = IDLE;
          if (bus.iREN && (starve_cnt < STARVE_LIMIT))
            next_cnt = starve_cnt + 1'b1;
        end
      end
      IGNT: begin
        if (!bus.iREN) begin
          next_state = IDLE;
        end else if (access) begin
          next_state = IDLE;
          next_cnt   = '0;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // RAM strobes and cache responses follow the registered grant only.
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iload    = '0;
    bus.dload    = '0;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    unique case (state)
      DGNT: begin
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.dload    = bus.ramload;
        bus.dwait    = ~access;
      end
      IGNT: begin
        bus.ramREN  = bus.iREN;
        bus.ramaddr = bus.iaddr;
        bus.iload   = bus.ramload;
        bus.iwait   = ~access;
      end
      default: ;
    endcase
  end

endmodule
